// File: rtl/hazard_tracker.sv
// Tracks destination tags of in-flight instructions (EX/MEM/WB) and raises a one-cycle load-use stall.
// Optional macro HAZARD_TRACKER_R0_ZERO_EN makes register 0 a hardwired zero (never stalls, never forwards).
module hazard_tracker #(
  parameter int REG_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_wr_en,
  input  logic                   id_is_load,
  input  logic [REG_W-1:0]       id_rs_a,
  input  logic [REG_W-1:0]       id_rs_b,
  input  logic                   id_use_a,
  input  logic                   id_use_b,
  input  logic                   flush,
  output logic                   stall,
  output logic [REG_W-1:0]       ex_rd,
  output logic [REG_W-1:0]       mem_rd,
  output logic [REG_W-1:0]       wb_rd,
  output logic                   ctrl_ex,
  output logic                   ctrl_mem,
  output logic                   ctrl_wb,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic                   r_ex_v, r_ex_we, r_ex_ld;
  logic [REG_W-1:0]       r_ex_rd;
  logic                   r_mem_v, r_mem_we;
  logic [REG_W-1:0]       r_mem_rd;
  logic                   r_wb_v, r_wb_we;
  logic [REG_W-1:0]       r_wb_rd;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  logic w_hit_a, w_hit_b, w_stall, w_issue;

  always_comb begin
    w_hit_a = id_use_a && (r_ex_rd == id_rs_a);
    w_hit_b = id_use_b && (r_ex_rd == id_rs_b);
`ifdef HAZARD_TRACKER_R0_ZERO_EN
    if (id_rs_a == '0) w_hit_a = 1'b0;
    if (id_rs_b == '0) w_hit_b = 1'b0;
`endif
    // flush wins over the stall so a squashed instruction never holds the front end
    w_stall = id_valid && !flush && r_ex_v && r_ex_we && r_ex_ld && (w_hit_a || w_hit_b);
    w_issue = id_valid && !w_stall && !flush;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_v      <= 1'b0;
      r_ex_we     <= 1'b0;
      r_ex_ld     <= 1'b0;
      r_ex_rd     <= '0;
      r_mem_v     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_rd    <= '0;
      r_wb_v      <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_we  <= r_mem_we;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_we <= r_ex_we;
      r_mem_rd <= r_ex_rd;
      if (w_issue) begin
        r_ex_v  <= 1'b1;
        r_ex_we <= id_wr_en;
        r_ex_ld <= id_is_load;
        r_ex_rd <= id_rd;
      end else begin
        r_ex_v  <= 1'b0;
        r_ex_we <= 1'b0;
        r_ex_ld <= 1'b0;
        r_ex_rd <= '0;
      end
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  // Load data only exists from MEM onward, so a load in EX is never a forwarding source
  always_comb begin
    ctrl_ex  = r_ex_v && r_ex_we && !r_ex_ld;
    ctrl_mem = r_mem_v && r_mem_we;
    ctrl_wb  = r_wb_v && r_wb_we;
`ifdef HAZARD_TRACKER_R0_ZERO_EN
    if (r_ex_rd == '0)  ctrl_ex  = 1'b0;
    if (r_mem_rd == '0) ctrl_mem = 1'b0;
    if (r_wb_rd == '0)  ctrl_wb  = 1'b0;
`endif
  end

  assign stall       = w_stall;
  assign ex_rd       = r_ex_rd;
  assign mem_rd      = r_mem_rd;
  assign wb_rd       = r_wb_rd;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// Randomized and directed bench for hazard_tracker against an instruction-level pipeline model.
module tb_hazard_tracker;

  localparam int REG_W   = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid, id_wr_en, id_is_load;
  logic [REG_W-1:0] id_rd, id_rs_a, id_rs_b;
  logic             id_use_a, id_use_b, flush;
  logic             stall;
  logic [REG_W-1:0] ex_rd, mem_rd, wb_rd;
  logic             ctrl_ex, ctrl_mem, ctrl_wb;
  logic [CW-1:0]    stall_count;

  always #5 clk = ~clk;

  hazard_tracker #(.REG_W(REG_W), .STALL_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rd(id_rd), .id_wr_en(id_wr_en), .id_is_load(id_is_load),
    .id_rs_a(id_rs_a), .id_rs_b(id_rs_b), .id_use_a(id_use_a), .id_use_b(id_use_b),
    .flush(flush), .stall(stall),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ctrl_ex(ctrl_ex), .ctrl_mem(ctrl_mem), .ctrl_wb(ctrl_wb),
    .stall_count(stall_count)
  );

  // Model: the three back-end slots hold whole instructions (or empty slots)
  typedef struct {
    bit v;
    int rd;
    bit we;
    bit ld;
  } instr_t;

  instr_t pipe[3];
  int     stallsSeen;
  int     errors = 0;
  int     checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic bit r0Zero();
`ifdef HAZARD_TRACKER_R0_ZERO_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit modelStall();
    bit ha, hb;
    ha = id_use_a && (pipe[0].rd == int'(id_rs_a)) && !(r0Zero() && id_rs_a == 0);
    hb = id_use_b && (pipe[0].rd == int'(id_rs_b)) && !(r0Zero() && id_rs_b == 0);
    return id_valid && !flush && pipe[0].v && pipe[0].we && pipe[0].ld && (ha || hb);
  endfunction

  function automatic bit forwards(input instr_t s, input bit fromEx);
    return s.v && s.we && !(fromEx && s.ld) && !(r0Zero() && s.rd == 0);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) pipe[i] = '{v: 0, rd: 0, we: 0, ld: 0};
    stallsSeen = 0;
  endtask

  task automatic checkRegs();
    checkOutput("exRd",   32'(ex_rd),   32'(pipe[0].rd));
    checkOutput("memRd",  32'(mem_rd),  32'(pipe[1].rd));
    checkOutput("wbRd",   32'(wb_rd),   32'(pipe[2].rd));
    checkOutput("ctrlEx", 32'(ctrl_ex), 32'(forwards(pipe[0], 1'b1)));
    checkOutput("ctrlMem",32'(ctrl_mem),32'(forwards(pipe[1], 1'b0)));
    checkOutput("ctrlWb", 32'(ctrl_wb), 32'(forwards(pipe[2], 1'b0)));
    checkOutput("stallCount", 32'(stall_count), 32'(stallsSeen > CNT_MAX ? CNT_MAX : stallsSeen));
  endtask

  task automatic applyStimulus(input bit v, input int rd, input bit we, input bit ld,
                               input int rsa, input int rsb, input bit ua, input bit ub, input bit fl);
    id_valid   = v;
    id_rd      = REG_W'(rd);
    id_wr_en   = we;
    id_is_load = ld;
    id_rs_a    = REG_W'(rsa);
    id_rs_b    = REG_W'(rsb);
    id_use_a   = ua;
    id_use_b   = ub;
    flush      = fl;
  endtask

  task automatic runCycle();
    bit expStall;
    #2;
    expStall = modelStall();
    checkOutput("stall", 32'(stall), 32'(expStall));
    @(posedge clk);
    if (!rst_n) begin
      modelReset();
    end else begin
      if (expStall) stallsSeen++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (id_valid && !expStall && !flush)
        pipe[0] = '{v: 1, rd: int'(id_rd), we: id_wr_en, ld: id_is_load};
      else
        pipe[0] = '{v: 0, rd: 0, we: 0, ld: 0};
    end
    #1;
    checkRegs();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    runCycle();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1, 9, 1, 1, 9, 9, 1, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkRegs();
    checkOutput("resetStall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // ALU result walking down the pipe
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkOutput("aluExRd", 32'(ex_rd), 32'd5);
    checkOutput("aluCtrlEx", 32'(ctrl_ex), 32'd1);
    idle();
    checkOutput("aluMemRd", 32'(mem_rd), 32'd5);
    idle();
    checkOutput("aluWbRd", 32'(wb_rd), 32'd5);
    checkOutput("aluCtrlExGone", 32'(ctrl_ex), 32'd0);
    idle();

    // load-use: one stall, then the consumer issues
    applyStimulus(1, 3, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 7, 1, 0, 3, 0, 1, 0, 0);
    #2;
    checkOutput("luStall", 32'(stall), 32'd1);
    checkOutput("luCtrlEx", 32'(ctrl_ex), 32'd0);
    runCycle();
    checkOutput("luMemRd", 32'(mem_rd), 32'd3);
    checkOutput("luCtrlMem", 32'(ctrl_mem), 32'd1);
    checkOutput("luCount", 32'(stall_count), 32'd1);
    runCycle();
    idle();

    // no false stalls
    applyStimulus(1, 3, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 8, 1, 0, 0, 3, 0, 0, 0);
    runCycle();
    applyStimulus(1, 3, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 8, 1, 0, 4, 0, 1, 0, 0);
    runCycle();
    idle();

    // flush beats stall
    applyStimulus(1, 3, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 7, 1, 0, 3, 0, 1, 0, 1);
    #2;
    checkOutput("flushStall", 32'(stall), 32'd0);
    runCycle();
    checkOutput("flushCtrlEx", 32'(ctrl_ex), 32'd0);
    checkOutput("flushCount", 32'(stall_count), 32'd1);
    idle();

    // reset arriving during a stall cycle
    applyStimulus(1, 6, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 2, 1, 0, 0, 6, 0, 1, 0);
    rst_n = 1'b0;
    runCycle();
    rst_n = 1'b1;
    checkOutput("midResetCount", 32'(stall_count), 32'd0);
    runCycle();
    idle();

    // saturate the counter
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 3, 1, 1, 0, 0, 0, 0, 0);
      runCycle();
      applyStimulus(1, 7, 1, 0, 0, 3, 0, 1, 0);
      runCycle();
      idle();
    end
    checkOutput("satCount", 32'(stall_count), 32'(CNT_MAX));

    // load to r0 then use r0
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(1, 7, 1, 0, 0, 0, 1, 0, 0);
`ifdef HAZARD_TRACKER_R0_ZERO_EN
    #2;
    checkOutput("r0Stall", 32'(stall), 32'd0);
    runCycle();
    checkOutput("r0CtrlMem", 32'(ctrl_mem), 32'd0);
`else
    runCycle();
`endif
    runCycle();
    idle();

    // random traffic with a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 9) == 0);
      runCycle();
    end
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
